// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86 pipeline encodings, controller state type and hazard flag bundle.
// Contents: icode/stat/register constants, state_t, hz_t, is_exc(), sat_inc().
package y86_pkg;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] RNONE    = 4'hF;

    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_RUN,
        ST_HALT
    } state_t;

    // Raw hazard decisions, meaningful only while the controller is running.
    typedef struct packed {
        logic f_stall;
        logic d_stall;
        logic d_bubble;
        logic e_bubble;
        logic m_bubble;
        logic w_stall;
    } hz_t;

    function automatic logic is_exc(input logic [2:0] s);
        return s == S_HLT || s == S_ADR || s == S_INS;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
    endfunction
endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: pipeline stage status seen by the hazard controller.
// Signals: decode icode/sources, execute icode/dstM/cnd, memory icode/stat, writeback stat.
// master drives the status (pipeline side), slave observes it (controller side).
interface pipe_ctrl_if;
    logic [3:0] d_icode;
    logic [3:0] d_src_a;
    logic [3:0] d_src_b;
    logic [3:0] e_icode;
    logic [3:0] e_dst_m;
    logic       e_cnd;
    logic [3:0] m_icode;
    logic [2:0] m_stat;
    logic [2:0] w_stat;

    modport master (
        output d_icode, d_src_a, d_src_b, e_icode, e_dst_m, e_cnd, m_icode, m_stat, w_stat
    );
    modport slave (
        input d_icode, d_src_a, d_src_b, e_icode, e_dst_m, e_cnd, m_icode, m_stat, w_stat
    );
endinterface

// File: rtl/pipe_ctrl_hazard.sv
// hazard_detect: combinational load/use, return, mispredict and exception detection.
// Ports: bus (pipe_ctrl_if.slave) stage status in; hz hazard flag bundle out.
module hazard_detect
    import y86_pkg::*;
(
    pipe_ctrl_if.slave bus,
    output hz_t        hz
);
    logic load_use;
    logic ret_pend;
    logic mispred;
    logic exc_m;
    logic exc_w;

    assign load_use = (bus.e_icode == I_MRMOVQ || bus.e_icode == I_POPQ) && bus.e_dst_m != RNONE &&
                      (bus.e_dst_m == bus.d_src_a || bus.e_dst_m == bus.d_src_b);
    assign ret_pend = bus.d_icode == I_RET || bus.e_icode == I_RET || bus.m_icode == I_RET;
    assign mispred  = bus.e_icode == I_JXX && !bus.e_cnd;
    assign exc_m    = is_exc(bus.m_stat);
    assign exc_w    = is_exc(bus.w_stat);

    // A decode stall always overrides a decode bubble.
    assign hz.f_stall  = load_use | ret_pend;
    assign hz.d_stall  = load_use;
    assign hz.d_bubble = ~load_use & (mispred | ret_pend);
    assign hz.e_bubble = mispred | load_use;
    assign hz.m_bubble = exc_m | exc_w;
    assign hz.w_stall  = exc_w;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: Y86 pipeline controller: INIT/RUN/HALT FSM, status latch and performance counters.
// Ports: clk_i, rst_n_i (async active-low); stage status inputs; stall/bubble controls,
// halted_o, stat_o, cycle/stall/bubble counters out.
module pipe_ctrl
    import y86_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [3:0]  D_icode_i,
    input  logic [3:0]  d_srcA_i,
    input  logic [3:0]  d_srcB_i,
    input  logic [3:0]  E_icode_i,
    input  logic [3:0]  E_dstM_i,
    input  logic        e_cnd_i,
    input  logic [3:0]  M_icode_i,
    input  logic [2:0]  m_stat_i,
    input  logic [2:0]  W_stat_i,
    output logic        F_stall_o,
    output logic        F_bubble_o,
    output logic        D_stall_o,
    output logic        D_bubble_o,
    output logic        E_bubble_o,
    output logic        M_bubble_o,
    output logic        W_stall_o,
    output logic        halted_o,
    output logic [2:0]  stat_o,
    output logic [31:0] cycle_cnt_o,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] bubble_cnt_o
);
    pipe_ctrl_if bus ();
    hz_t         hz;
    state_t      state;
    logic        init;
    logic        run;
    logic        halt;
    logic [31:0] cycle_q;
    logic [31:0] stall_q;
    logic [31:0] bubble_q;

    assign bus.d_icode = D_icode_i;
    assign bus.d_src_a = d_srcA_i;
    assign bus.d_src_b = d_srcB_i;
    assign bus.e_icode = E_icode_i;
    assign bus.e_dst_m = E_dstM_i;
    assign bus.e_cnd   = e_cnd_i;
    assign bus.m_icode = M_icode_i;
    assign bus.m_stat  = m_stat_i;
    assign bus.w_stat  = W_stat_i;

    hazard_detect u_hazard (
        .bus (bus),
        .hz  (hz)
    );

    assign init = state == ST_INIT;
    assign run  = state == ST_RUN;
    assign halt = state == ST_HALT;

    // Reset forces state to INIT asynchronously, so these go to INIT values at once.
    assign F_bubble_o = 1'b0;
    assign F_stall_o  = halt | (run & hz.f_stall);
    assign D_stall_o  = halt | (run & hz.d_stall);
    assign D_bubble_o = init | (run & hz.d_bubble);
    assign E_bubble_o = init | halt | (run & hz.e_bubble);
    assign M_bubble_o = init | halt | (run & hz.m_bubble);
    assign W_stall_o  = halt | (run & hz.w_stall);

    assign cycle_cnt_o  = cycle_q;
    assign stall_cnt_o  = stall_q;
    assign bubble_cnt_o = bubble_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state    <= ST_INIT;
            stat_o   <= S_AOK;
            halted_o <= 1'b0;
            cycle_q  <= '0;
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            case (state)
                ST_INIT: state <= ST_RUN;
                ST_RUN: begin
                    cycle_q  <= sat_inc(cycle_q, 1'b1);
                    stall_q  <= sat_inc(stall_q, hz.f_stall);
                    bubble_q <= sat_inc(bubble_q, hz.d_bubble | hz.e_bubble);
                    if (hz.w_stall) begin
                        stat_o   <= W_stat_i;
                        halted_o <= 1'b1;
                        state    <= ST_HALT;
                    end
                end
                ST_HALT: state <= ST_HALT;
                default: state <= ST_INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench for pipe_ctrl with directed hazard, halt, reset and saturation vectors.
module tb_pipe_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        f_stall, f_bubble, d_stall, d_bubble, e_bubble, m_bubble, w_stall;
    logic        halted;
    logic [2:0]  stat;
    logic [31:0] cyc, stl, bub;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        string       name;
        logic [6:0]  ctl;
        logic        h;
        logic [2:0]  st;
        logic [31:0] cyc;
        logic [31:0] stl;
        logic [31:0] bub;
    } exp_t;

    exp_t        q[$];
    logic [31:0] m_cyc = 0, m_stl = 0, m_bub = 0;

    pipe_ctrl_if stim ();

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .D_icode_i    (stim.d_icode),
        .d_srcA_i     (stim.d_src_a),
        .d_srcB_i     (stim.d_src_b),
        .E_icode_i    (stim.e_icode),
        .E_dstM_i     (stim.e_dst_m),
        .e_cnd_i      (stim.e_cnd),
        .M_icode_i    (stim.m_icode),
        .m_stat_i     (stim.m_stat),
        .W_stat_i     (stim.w_stat),
        .F_stall_o    (f_stall),
        .F_bubble_o   (f_bubble),
        .D_stall_o    (d_stall),
        .D_bubble_o   (d_bubble),
        .E_bubble_o   (e_bubble),
        .M_bubble_o   (m_bubble),
        .W_stall_o    (w_stall),
        .halted_o     (halted),
        .stat_o       (stat),
        .cycle_cnt_o  (cyc),
        .stall_cnt_o  (stl),
        .bubble_cnt_o (bub)
    );

    task automatic cmp(input string nm, input string what, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s %s got %h want %h", nm, what, got, want);
        end
    endtask

    // Monitor: outputs are stable at the falling edge, so compare against the queued expectation there.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                cmp(e.name, "ctl", {25'd0, f_stall, f_bubble, d_stall, d_bubble, e_bubble, m_bubble, w_stall}, {25'd0, e.ctl});
                cmp(e.name, "halted", {31'd0, halted}, {31'd0, e.h});
                cmp(e.name, "stat", {29'd0, stat}, {29'd0, e.st});
                cmp(e.name, "cycle_cnt", cyc, e.cyc);
                cmp(e.name, "stall_cnt", stl, e.stl);
                cmp(e.name, "bubble_cnt", bub, e.bub);
            end
        end
    end

    function automatic logic [31:0] sat(input logic [31:0] v, input logic en);
        return (en && v != 32'hFFFF_FFFF) ? v + 1 : v;
    endfunction

    task automatic set_in(input logic [3:0] di, input logic [3:0] sa, input logic [3:0] sb,
                          input logic [3:0] ei, input logic [3:0] edm, input logic cnd,
                          input logic [3:0] mi, input logic [2:0] ms, input logic [2:0] ws);
        stim.d_icode = di; stim.d_src_a = sa; stim.d_src_b = sb;
        stim.e_icode = ei; stim.e_dst_m = edm; stim.e_cnd = cnd;
        stim.m_icode = mi; stim.m_stat = ms; stim.w_stat = ws;
    endtask

    task automatic idle();
        set_in(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 3'd1, 3'd1);
    endtask

    // ctl = {F_stall, F_bubble, D_stall, D_bubble, E_bubble, M_bubble, W_stall}
    task automatic step(input string nm, input logic [6:0] ctl, input logic h, input logic [2:0] st, input logic run);
        exp_t e;
        e.name = nm; e.ctl = ctl; e.h = h; e.st = st;
        e.cyc = m_cyc; e.stl = m_stl; e.bub = m_bub;
        q.push_back(e);
        @(negedge clk);
        @(posedge clk);
        if (run && rst_n) begin
            m_cyc = sat(m_cyc, 1'b1);
            m_stl = sat(m_stl, ctl[6]);
            m_bub = sat(m_bub, ctl[3] | ctl[2]);
        end
        #1;
    endtask

    localparam logic [6:0] C_INIT = 7'b0001110;
    localparam logic [6:0] C_HALT = 7'b1010111;
    localparam logic [6:0] C_NONE = 7'b0000000;

    initial begin
        idle();
        step("reset", C_INIT, 0, 3'd1, 0);
        rst_n = 1'b1;
        step("init", C_INIT, 0, 3'd1, 0);
        step("idle0", C_NONE, 0, 3'd1, 1);
        step("idle1", C_NONE, 0, 3'd1, 1);
        set_in(4'h1, 4'h3, 4'hF, 4'h5, 4'h3, 1'b1, 4'h1, 3'd1, 3'd1);
        step("load_use", 7'b1010100, 0, 3'd1, 1);
        set_in(4'h9, 4'hF, 4'hF, 4'h7, 4'hF, 1'b0, 4'h1, 3'd1, 3'd1);
        step("mispred", 7'b1001100, 0, 3'd1, 1);
        set_in(4'h9, 4'hF, 4'h4, 4'hB, 4'h4, 1'b1, 4'h1, 3'd1, 3'd1);
        step("ret_lu", 7'b1010100, 0, 3'd1, 1);
        set_in(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h9, 3'd1, 3'd1);
        step("ret_m", 7'b1001000, 0, 3'd1, 1);
        set_in(4'h1, 4'hF, 4'hF, 4'h5, 4'hF, 1'b1, 4'h1, 3'd1, 3'd1);
        step("lu_rnone", C_NONE, 0, 3'd1, 1);
        set_in(4'h1, 4'hF, 4'h2, 4'hB, 4'h2, 1'b1, 4'h1, 3'd1, 3'd1);
        step("lu_popq", 7'b1010100, 0, 3'd1, 1);
        set_in(4'h1, 4'h4, 4'h5, 4'h5, 4'h3, 1'b1, 4'h1, 3'd1, 3'd1);
        step("lu_nomatch", C_NONE, 0, 3'd1, 1);
        set_in(4'h1, 4'hF, 4'hF, 4'h7, 4'hF, 1'b1, 4'h1, 3'd1, 3'd1);
        step("jxx_taken", C_NONE, 0, 3'd1, 1);
        set_in(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 3'd0, 3'd1);
        step("mstat0", C_NONE, 0, 3'd1, 1);
        set_in(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 3'd3, 3'd1);
        step("exc_m", 7'b0000010, 0, 3'd1, 1);
        set_in(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 3'd1, 3'd3);
        step("exc_w", 7'b0000011, 0, 3'd1, 1);
        idle();
        step("halt0", C_HALT, 1, 3'd3, 0);
        set_in(4'h9, 4'h3, 4'hF, 4'h5, 4'h3, 1'b0, 4'h9, 3'd4, 3'd1);
        step("halt1", C_HALT, 1, 3'd3, 0);
        rst_n = 1'b0;
        m_cyc = 0; m_stl = 0; m_bub = 0;
        step("rst_halt", C_INIT, 0, 3'd1, 0);
        idle();
        rst_n = 1'b1;
        step("init2", C_INIT, 0, 3'd1, 0);
        for (int i = 0; i < 4; i++) step($sformatf("count%0d", i), C_NONE, 0, 3'd1, 1);
        force dut.cycle_q = 32'hFFFF_FFFE;
        #1 release dut.cycle_q;
        m_cyc = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) step($sformatf("sat%0d", i), C_NONE, 0, 3'd1, 1);
        step("sat_hold", C_NONE, 0, 3'd1, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have ports: clk_i in 1 clock; rst_n_i in 1 reset, asynchronous, active-low. One clock domain.
REQ-002 SHALL have inputs: D_icode_i 4 (icode in decode reg); d_srcA_i, d_srcB_i 4 each (decode source regs, 4'hF = none).
REQ-003 SHALL have inputs: E_icode_i 4, E_dstM_i 4, e_cnd_i 1 (execute-stage condition); M_icode_i 4; m_stat_i 3; W_stat_i 3.
REQ-004 SHALL have outputs: F_stall_o, F_bubble_o, D_stall_o, D_bubble_o, E_bubble_o, M_bubble_o, W_stall_o, 1 bit each.
REQ-005 SHALL have outputs: halted_o 1; stat_o 3 (latched machine status); cycle_cnt_o, stall_cnt_o, bubble_cnt_o 32 bits each.

Function
REQ-006 Encodings SHALL be: icode MRMOVQ=5, JXX=7, RET=9, POPQ=B; stat AOK=1, HLT=2, ADR=3, INS=4; RNONE=F.
REQ-007 load_use SHALL be E_icode in {5,B} AND E_dstM != F AND E_dstM in {d_srcA, d_srcB}.
REQ-008 ret_pend SHALL be RET present in any of D_icode, E_icode, M_icode.
REQ-009 mispred SHALL be E_icode==JXX AND e_cnd_i==0.
REQ-010 exc_m SHALL be m_stat in {2,3,4}; exc_w SHALL be W_stat in {2,3,4}.
REQ-011 FSM states SHALL be INIT, RUN, HALT.
REQ-012 INIT: entered on reset. D_bubble, E_bubble and M_bubble asserted; all stalls 0. Goes to RUN after exactly one clock.
REQ-013 RUN: F_stall = load_use OR ret_pend; D_stall = load_use; D_bubble = mispred OR (ret_pend AND NOT load_use); E_bubble = mispred OR load_use; M_bubble = exc_m OR exc_w; W_stall = exc_w.
REQ-014 RUN: D_stall and D_bubble SHALL never both be 1; D_stall wins.
REQ-015 RUN with exc_w: SHALL latch W_stat_i into stat_o and go to HALT on the next edge.
REQ-016 HALT: F_stall, D_stall, W_stall = 1; E_bubble, M_bubble = 1; D_bubble = 0; halted_o = 1. Exit SHALL be by reset only.
REQ-017 F_bubble_o SHALL be 0 in all states.
REQ-018 Stall/bubble outputs SHALL be combinational from state and inputs, with zero-cycle latency.
REQ-019 cycle_cnt SHALL increment every RUN cycle.
REQ-020 stall_cnt SHALL increment on RUN cycles with F_stall = 1.
REQ-021 bubble_cnt SHALL increment on RUN cycles with D_bubble OR E_bubble = 1.
REQ-022 All counters SHALL saturate at 32'hFFFFFFFF (no wrap) and SHALL freeze in INIT and HALT.
REQ-023 In the cycle RUN goes to HALT, outputs SHALL follow RUN equations and counters SHALL update as RUN.

Reset
REQ-024 rst_n_i low SHALL immediately force: state INIT, stat_o = AOK (1), halted_o = 0, all counters 0. This holds from any state, including mid-HALT and mid-stall.
REQ-025 While reset is held, outputs SHALL be INIT values (D/E/M bubble = 1, others 0).

Structure
REQ-026 icode, stat and RNONE constants and the FSM state typedef SHALL live in a shared package, y86_pkg, used by all pipeline stages.
REQ-027 Hazard equations (REQ-007..010, REQ-013) SHALL be in one combinational sub-module, hazard_detect. The FSM, status latch and counters SHALL be in pipe_ctrl.

Verification
REQ-028 Load/use: E_icode=5, E_dstM=3, d_srcA=3 in RUN -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0; stall_cnt+1.
REQ-029 Mispredict: E_icode=7, e_cnd=0, D_icode=9 -> D_bubble=1, E_bubble=1, F_stall=1; bubble_cnt+1.
REQ-030 Ret combined with load/use: D_icode=9, E_icode=B, E_dstM=4, d_srcB=4 -> D_stall=1, D_bubble=0, E_bubble=1.
REQ-031 Exception: m_stat=3 for one cycle -> M_bubble=1. Next cycle W_stat=3 -> W_stall=1, then HALT with halted_o=1, stat_o=3, counters frozen.
REQ-032 Reset in HALT: drop rst_n_i mid-cycle -> outputs go to INIT values asynchronously. After release: INIT for 1 cycle, then RUN, cycle_cnt counts 1,2,3.
REQ-033 Saturation: force cycle_cnt to 32'hFFFFFFFE, run 3 cycles -> holds at 32'hFFFFFFFF.
